// File: rtl/ysyx_25010008_icache_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25010008_icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - FSM state encoding
//   - AXI-style read response codes
//   - default line geometry
//   - response-code helper
// ----------------------------------------------------------------------------
package ysyx_25010008_icache_pkg;

    // Default geometry: 16-byte lines (4 words), 16 lines
    localparam int ICACHE_OFFSET_W = 4;
    localparam int ICACHE_INDEX_W  = 4;
    localparam int ICACHE_ADDR_W   = 32;

    // Read response codes
    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MISS_AR = 3'd2,
        ST_MISS_R  = 3'd3,
        ST_RESP    = 3'd4
    } icache_state_e;

    // Collapse the sticky refill error flag into the code returned to the IFU
    function automatic logic [1:0] f_refill_resp(input logic err);
        return err ? RRESP_SLVERR : RRESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_25010008_icache_array.sv
// ----------------------------------------------------------------------------
// ysyx_25010008_icache_array
// Valid / tag / data storage of the instruction cache.
//   i_clock, i_reset        : clock, asynchronous active-high reset (valid bits)
//   i_clr_all               : clear every valid bit (wins over a line write)
//   i_rd_index, i_rd_word   : combinational read address
//   o_rd_valid/tag/data     : selected line valid, tag and word
//   i_wr_en, i_wr_index,
//   i_wr_word, i_wr_data    : synchronous single-word data write
//   i_line_we, i_line_tag,
//   i_line_valid            : synchronous tag + valid write for i_wr_index
// ----------------------------------------------------------------------------
module ysyx_25010008_icache_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24,
    parameter int WORD_W  = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clr_all,
    input  logic [INDEX_W-1:0] i_rd_index,
    input  logic [WORD_W-1:0]  i_rd_word,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [31:0]        o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [WORD_W-1:0]  i_wr_word,
    input  logic [31:0]        i_wr_data,
    input  logic               i_line_we,
    input  logic [TAG_W-1:0]   i_line_tag,
    input  logic               i_line_valid
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << WORD_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES*WORDS];

    // Valid bits: async reset, global clear has priority over a line fill
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= {LINES{1'b0}};
        end else if (i_clr_all) begin
            r_valid <= {LINES{1'b0}};
        end else if (i_line_we) begin
            r_valid[i_wr_index] <= i_line_valid;
        end
    end

    // Tag and data storage: plain RAM-style writes, no reset needed
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
        end
        if (i_line_we) begin
            r_tag[i_wr_index] <= i_line_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[{i_rd_index, i_rd_word}];

endmodule

// File: rtl/ysyx_25010008_icache.sv
// ----------------------------------------------------------------------------
// ysyx_25010008_icache
// Direct-mapped read-only instruction cache between the IFU fetch port and
// port 0 of the bus arbiter. Hits are answered locally; misses refill the
// whole line with sequential single-beat reads. fence_i invalidates all lines.
//   clock, reset          : clock, asynchronous active-high reset
//   fence_i               : one-cycle pulse, invalidate all lines
//   ifu_ar* / ifu_r*      : fetch request / response (valid-ready)
//   mem_ar* / mem_r*      : refill request / data towards the arbiter
//   hit, miss             : one-cycle pulses from the lookup cycle
// ----------------------------------------------------------------------------
module ysyx_25010008_icache
    import ysyx_25010008_icache_pkg::*;
#(
    parameter int OFFSET_W = ICACHE_OFFSET_W,
    parameter int INDEX_W  = ICACHE_INDEX_W,
    parameter int TAG_W    = ICACHE_ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fence_i,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    output logic        hit,
    output logic        miss
);

    localparam int WORD_W = OFFSET_W - 2;
    localparam logic [WORD_W-1:0] LAST_BEAT = {WORD_W{1'b1}};
    localparam logic [WORD_W-1:0] BEAT_ONE  = {{(WORD_W-1){1'b0}}, 1'b1};

    icache_state_e r_state;
    icache_state_e w_state_nxt;

    logic [31:2]       r_addr;
    logic [WORD_W-1:0] r_beat;
    logic              r_err;
    logic              r_kill;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic [WORD_W-1:0]  w_word;
    logic               w_arr_valid;
    logic [TAG_W-1:0]   w_arr_tag;
    logic [31:0]        w_arr_data;
    logic               w_lookup_hit;
    logic               w_beat_done;
    logic               w_last;
    logic               w_err_nxt;
    logic               w_line_valid;
    logic [31:0]        w_req_word;
    logic               w_unused_lsb;

    // Byte-lane bits of the fetch address carry no information
    assign w_unused_lsb = &{1'b0, ifu_araddr[1:0]};

    assign w_tag   = r_addr[31:OFFSET_W+INDEX_W];
    assign w_index = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign w_word  = r_addr[OFFSET_W-1:2];

    // A fence in the lookup cycle forces a miss even if the line was valid
    assign w_lookup_hit = w_arr_valid & (w_arr_tag == w_tag) & ~fence_i;
    assign w_beat_done  = (r_state == ST_MISS_R) & mem_rvalid;
    assign w_last       = (r_beat == LAST_BEAT);
    assign w_err_nxt    = r_err | (mem_rresp != RRESP_OKAY);
    // A line is only validated if every beat was OKAY and no fence hit the refill
    assign w_line_valid = ~w_err_nxt & ~r_kill & ~fence_i;
    // Requested word never lies after the current beat; bypass when equal
    assign w_req_word   = (w_word == r_beat) ? mem_rdata : w_arr_data;

    ysyx_25010008_icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .WORD_W  (WORD_W)
    ) u_array (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_clr_all    (fence_i),
        .i_rd_index   (w_index),
        .i_rd_word    (w_word),
        .o_rd_valid   (w_arr_valid),
        .o_rd_tag     (w_arr_tag),
        .o_rd_data    (w_arr_data),
        .i_wr_en      (w_beat_done),
        .i_wr_index   (w_index),
        .i_wr_word    (r_beat),
        .i_wr_data    (mem_rdata),
        .i_line_we    (w_beat_done & w_last),
        .i_line_tag   (w_tag),
        .i_line_valid (w_line_valid)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ifu_arvalid) begin
                    w_state_nxt = ST_LOOKUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (w_lookup_hit) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_MISS_AR;
                end
            end
            ST_MISS_AR: begin
                if (mem_arready) begin
                    w_state_nxt = ST_MISS_R;
                end else begin
                    w_state_nxt = ST_MISS_AR;
                end
            end
            ST_MISS_R: begin
                if (mem_rvalid && w_last) begin
                    w_state_nxt = ST_RESP;
                end else if (mem_rvalid) begin
                    w_state_nxt = ST_MISS_AR;
                end else begin
                    w_state_nxt = ST_MISS_R;
                end
            end
            ST_RESP: begin
                if (ifu_rready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request address, refill beat/error/kill tracking and response holding
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr  <= 30'd0;
            r_beat  <= {WORD_W{1'b0}};
            r_err   <= 1'b0;
            r_kill  <= 1'b0;
            r_rdata <= 32'd0;
            r_rresp <= RRESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_kill <= 1'b0;
                    if (ifu_arvalid) begin
                        r_addr <= ifu_araddr[31:2];
                    end
                end
                ST_LOOKUP: begin
                    if (w_lookup_hit) begin
                        r_rdata <= w_arr_data;
                        r_rresp <= RRESP_OKAY;
                    end else begin
                        r_beat <= {WORD_W{1'b0}};
                        r_err  <= 1'b0;
                    end
                end
                ST_MISS_AR: begin
                    if (fence_i) begin
                        r_kill <= 1'b1;
                    end
                end
                ST_MISS_R: begin
                    if (fence_i) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        r_err <= w_err_nxt;
                        if (w_last) begin
                            r_rdata <= w_req_word;
                            r_rresp <= f_refill_resp(w_err_nxt);
                        end else begin
                            r_beat <= r_beat + BEAT_ONE;
                        end
                    end
                end
                ST_RESP: begin
                    if (ifu_rready) begin
                        r_kill <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from registered state; reset forces them low at once
    assign ifu_arready = (r_state == ST_IDLE) & ~reset;
    assign ifu_rvalid  = (r_state == ST_RESP);
    assign ifu_rdata   = r_rdata;
    assign ifu_rresp   = r_rresp;
    assign mem_arvalid = (r_state == ST_MISS_AR);
    assign mem_araddr  = mem_arvalid ? {w_tag, w_index, r_beat, 2'b00} : 32'd0;
    assign mem_rready  = (r_state == ST_MISS_R);
    assign hit         = (r_state == ST_LOOKUP) & w_lookup_hit;
    assign miss        = (r_state == ST_LOOKUP) & ~w_lookup_hit;

endmodule
